instr_fetch_unit: RTL

- Producer end of the decode-stage instruction interface.
- Holds the fetch PC and issues single-outstanding requests to instruction memory.
- Buffers returned words in a 2-entry queue and presents instr/pc/valid to decode.
- Drives flush_out (NOP-injection select) when no valid instruction is presented, and squashes queued and in-flight fetches on a redirect from execute.

---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit feeding the decode stage
//
// Holds the fetch PC. Issues at most one outstanding request to instruction memory.
// Buffers returned words in a 2-entry queue and presents them to decode.
// A redirect from execute squashes both queued words and in-flight fetches.
//
// Ports:
//   clk_in          clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   imem_req_out    fetch request valid; held with imem_addr_out until ack
//   imem_addr_out   word-aligned fetch address
//   imem_ack_in     memory completes the current request, data valid same cycle
//   imem_rdata_in   instruction word returned with the ack
//   redirect_in     one-cycle redirect pulse from execute
//   redirect_pc_in  redirect target (low two bits ignored)
//   ready_in        decode accepts the presented instruction this cycle
//   valid_out       instr_out/pc_out carry a real instruction
//   instr_out       instruction word, NOP_INSTR when not valid
//   pc_out          PC of instr_out, 0 when not valid
//   flush_out       decode must substitute a NOP (inverse of valid_out)

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        ready_in,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        flush_out
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DISCARD
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_nxt;
    logic [31:0] addr_nxt;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic        ack;
    logic        pending;
    logic        push;
    logic        pop;
    logic        wr_idx;

    always_comb begin
        // An ack only counts against a request actually on the bus.
        ack      = imem_req_out & imem_ack_in;
        pending  = imem_req_out & ~imem_ack_in;
        valid_out = (count != 2'd0) & ~redirect_in;
        flush_out = ~valid_out;
        instr_out = valid_out ? q_instr[0] : NOP_INSTR;
        pc_out    = valid_out ? q_pc[0] : 32'h0000_0000;
        pop       = valid_out & ready_in;
        // Data returned while discarding belongs to a squashed fetch.
        push      = ack & (state == S_FETCH) & ~redirect_in;
        // Push at count=1 with a pop lands in slot 0 after the shift.
        wr_idx    = count[0] & ~pop;
        count_nxt = redirect_in ? 2'd0 : count + {1'b0, push} - {1'b0, pop};

        fetch_pc_nxt = fetch_pc;
        if (redirect_in) begin
            fetch_pc_nxt = redirect_pc_in & ALIGN_MASK;
        end else if (push) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
        end

        state_nxt = state;
        if (redirect_in) begin
            // A request still waiting for its ack must finish before a new one.
            state_nxt = pending ? S_DISCARD : S_FETCH;
        end else begin
            case (state)
                S_FETCH:   state_nxt = (count_nxt <= 2'd1) ? S_FETCH : S_HOLD;
                S_HOLD:    state_nxt = (count_nxt <= 2'd1) ? S_FETCH : S_HOLD;
                S_DISCARD: state_nxt = ack ? S_FETCH : S_DISCARD;
                default:   state_nxt = S_FETCH;
            endcase
        end

        // Address stays frozen while a request waits; otherwise it tracks fetch_pc.
        addr_nxt = pending ? imem_addr_out : fetch_pc_nxt;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= S_FETCH;
            fetch_pc      <= RESET_PC & ALIGN_MASK;
            imem_req_out  <= 1'b0;
            imem_addr_out <= RESET_PC & ALIGN_MASK;
            count         <= 2'd0;
            q_pc[0]       <= 32'h0;
            q_pc[1]       <= 32'h0;
            q_instr[0]    <= 32'h0;
            q_instr[1]    <= 32'h0;
        end else begin
            state         <= state_nxt;
            fetch_pc      <= fetch_pc_nxt;
            imem_req_out  <= (state_nxt != S_HOLD);
            imem_addr_out <= addr_nxt;
            count         <= count_nxt;
            if (!redirect_in) begin
                if (pop) begin
                    q_pc[0]    <= q_pc[1];
                    q_instr[0] <= q_instr[1];
                end
                if (push) begin
                    q_pc[wr_idx]    <= fetch_pc;
                    q_instr[wr_idx] <= imem_rdata_in;
                end
            end
        end
    end

endmodule
